// File: rtl/mult_mac_pipe.sv
// Pipelined multiply / multiply-accumulate for the wave/VGA datapath.
// Four register levels: input capture, product, result (accumulate), and
// scaled/rounded/saturated output. A sample accepted on edge k appears on the
// outputs after edge k+3. There is no backpressure.
module mult_mac_pipe #(
  parameter int unsigned A_W    = 10,
  parameter int unsigned B_W    = 10,
  parameter bit          SIGNED = 1'b1,
  parameter int unsigned GUARD  = 8,
  parameter int unsigned SHIFT  = 0,
  parameter int unsigned OUT_W  = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [A_W-1:0]   in_a,
  input  logic [B_W-1:0]   in_b,
  input  logic             acc_mode,
  input  logic             in_last,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_p,
  output logic             out_sat
);

  localparam int unsigned PROD_W = A_W + B_W;
  localparam int unsigned ACC_W  = PROD_W + GUARD;
  // One extra bit so the rounding add can never wrap.
  localparam int unsigned RW     = ACC_W + 1;
  // 2^(SHIFT-1), or zero when no shift is applied.
  localparam logic [RW-1:0] RndConst = (RW'(1) << SHIFT) >> 1;

  // Stage 1: captured sample
  logic             s1_valid_q, s1_valid_d;
  logic             s1_mode_q, s1_mode_d;
  logic             s1_last_q, s1_last_d;
  logic [A_W-1:0]   s1_a_q, s1_a_d;
  logic [B_W-1:0]   s1_b_q, s1_b_d;

  // Stage 2: product
  logic             s2_valid_q, s2_valid_d;
  logic             s2_mode_q, s2_mode_d;
  logic             s2_last_q, s2_last_d;
  logic [PROD_W-1:0] s2_prod_q, s2_prod_d;

  // Stage 3: result and running accumulator
  logic             res_valid_q, res_valid_d;
  logic [ACC_W-1:0] res_q, res_d;
  logic [ACC_W-1:0] acc_q, acc_d;

  // Stage 4: outputs
  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_p_q, out_p_d;
  logic             out_sat_q, out_sat_d;

  // Combinational intermediates
  logic signed [PROD_W-1:0] a_ext, b_ext, prod_s;
  logic [ACC_W-1:0]         prod_ext;
  logic [RW-1:0]            res_ext, rnd_sum, r_val;
  logic signed [RW-1:0]     rnd_sum_s, r_val_s;
  logic [OUT_W-1:0]         sat_p;
  logic                     sat_flag;

  // Stage 1 next state: mode/last are only meaningful on an accepted sample
  always_comb begin
    s1_valid_d = in_valid;
    s1_mode_d  = in_valid & acc_mode;
    s1_last_d  = in_valid & acc_mode & in_last;
    s1_a_d     = in_valid ? in_a : s1_a_q;
    s1_b_d     = in_valid ? in_b : s1_b_q;
  end

  // Stage 2 next state: full-width product, operands extended per signedness
  always_comb begin
    if (SIGNED) begin
      a_ext = PROD_W'($signed(s1_a_q));
      b_ext = PROD_W'($signed(s1_b_q));
    end else begin
      a_ext = PROD_W'(s1_a_q);
      b_ext = PROD_W'(s1_b_q);
    end
    // The low PROD_W bits are exact for both signed and unsigned operands.
    prod_s     = a_ext * b_ext;
    s2_prod_d  = prod_s;
    s2_valid_d = s1_valid_q;
    s2_mode_d  = s1_mode_q;
    s2_last_d  = s1_last_q;
  end

  // Stage 3 next state: standalone product or closing accumulation
  always_comb begin
    if (SIGNED) begin
      prod_ext = ACC_W'($signed(s2_prod_q));
    end else begin
      prod_ext = ACC_W'(s2_prod_q);
    end
    res_valid_d = s2_valid_q & (~s2_mode_q | s2_last_q);
    res_d       = (s2_mode_q ? acc_q : '0) + prod_ext;
    acc_d       = acc_q;
    if (s2_valid_q && s2_mode_q) begin
      // Closing sample clears the accumulator on the same edge it is consumed.
      acc_d = s2_last_q ? '0 : (acc_q + prod_ext);
    end
  end

  // Round-half-up then shift, arithmetic for signed data and logical otherwise
  always_comb begin
    if (SIGNED) begin
      res_ext = RW'($signed(res_q));
    end else begin
      res_ext = RW'(res_q);
    end
    rnd_sum   = res_ext + RndConst;
    rnd_sum_s = rnd_sum;
    r_val_s   = rnd_sum_s >>> SHIFT;
    if (SIGNED) begin
      r_val = r_val_s;
    end else begin
      r_val = rnd_sum >> SHIFT;
    end
  end

  if (OUT_W < RW) begin : gen_sat
    // Clamp to the output range when the rounded value does not fit
    always_comb begin
      sat_flag = 1'b0;
      sat_p    = r_val[OUT_W-1:0];
      if (SIGNED) begin
        if (r_val[RW-1:OUT_W-1] != {(RW-OUT_W+1){r_val[RW-1]}}) begin
          sat_flag = 1'b1;
          sat_p    = r_val[RW-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        end
      end else begin
        if (|r_val[RW-1:OUT_W]) begin
          sat_flag = 1'b1;
          sat_p    = '1;
        end
      end
    end
  end else begin : gen_no_sat
    // Output is wide enough for every value: extend, never clamp
    always_comb begin
      sat_flag = 1'b0;
      if (SIGNED) begin
        sat_p = OUT_W'($signed(r_val));
      end else begin
        sat_p = OUT_W'(r_val);
      end
    end
  end

  // Stage 4 next state: outputs hold their last value between results
  always_comb begin
    out_valid_d = res_valid_q;
    out_p_d     = res_valid_q ? sat_p : out_p_q;
    out_sat_d   = res_valid_q ? sat_flag : out_sat_q;
  end

  // Pipeline, accumulator and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_mode_q   <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s2_valid_q  <= 1'b0;
      s2_mode_q   <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_prod_q   <= '0;
      res_valid_q <= 1'b0;
      res_q       <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_p_q     <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_mode_q   <= s1_mode_d;
      s1_last_q   <= s1_last_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s2_valid_q  <= s2_valid_d;
      s2_mode_q   <= s2_mode_d;
      s2_last_q   <= s2_last_d;
      s2_prod_q   <= s2_prod_d;
      res_valid_q <= res_valid_d;
      res_q       <= res_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_p_q     <= out_p_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_p     = out_p_q;
  assign out_sat   = out_sat_q;

endmodule

// File: doc/mult_mac_pipe.md
Name: mult_mac_pipe

Overview:
- Parametrised, pipelined multiplier for the wave/VGA datapath. Generalises the 10x10 signed combinational multiply.
- Adds selectable signedness, per-sample multiply or grouped multiply-accumulate, output right-shift with rounding, and saturation to a narrower output.
- Fixed 3-cycle latency, valid-qualified streaming, no backpressure.
- Sits between sample scaling/windowing logic and display coordinate generation.

Parameters:
- A_W, 10, width of operand a.
- B_W, 10, width of operand b.
- SIGNED, 1, 1 = two's-complement operands/result; 0 = unsigned.
- GUARD, 8, extra accumulator bits; ACC_W = A_W+B_W+GUARD.
- SHIFT, 0, right shift applied to the result before output (0..ACC_W-1).
- OUT_W, 20, output width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  sample qualifier.
- in_a  in  A_W  operand a.
- in_b  in  B_W  operand b.
- acc_mode  in  1  1 = sample joins accumulation group; 0 = standalone multiply.
- in_last  in  1  with acc_mode=1: closes the group. Ignored when acc_mode=0.
- out_valid  out  1  result qualifier, single-cycle pulse per result.
- out_p  out  OUT_W  scaled, rounded, saturated result.
- out_sat  out  1  out_p was clamped; valid with out_valid.

Behaviour:
- Reset (asynchronous, any time): all pipeline registers, the accumulator and the valid bits clear. out_valid=0, out_p=0, out_sat=0. A partially built group is discarded and the next group starts from 0.
- No ready signal. A sample is accepted on every rising edge with in_valid=1. in_valid=0 inserts a bubble; the accumulator holds.
- Stage 1 registers a, b, valid, acc_mode and last.
- Stage 2 computes the full product, A_W+B_W bits, sign- or zero-extended per SIGNED.
- Stage 3 forms the result, then applies scale, rounding and saturation, and registers the outputs.
- Latency: a sample accepted on edge k produces out_valid=1 after edge k+3. One result per clock is sustained.
- acc_mode=0:
  - Result = product of that sample alone.
  - The accumulator is neither used nor modified, so an open group survives interleaved standalone samples.
  - out_valid pulses for every such sample.
- acc_mode=1, in_last=0:
  - acc <= acc + product. No output.
- acc_mode=1, in_last=1:
  - Result = acc + product. out_valid pulses. acc <= 0 on the same edge.
  - A one-sample group (in_last on the first sample) outputs its product alone.
- Accumulator width and overflow:
  - ACC_W bits; arithmetic wraps modulo 2^ACC_W.
  - Groups of up to 2^GUARD full-scale terms are guaranteed exact.
- Scale and round (SHIFT>0):
  - r = (result + 2^(SHIFT-1)) >> SHIFT.
  - Shift is arithmetic when SIGNED=1, logical when SIGNED=0.
  - This is round-half-up, toward +inf on ties.
  - The rounding add is done in ACC_W+1 bits, so it cannot wrap.
  - SHIFT=0: r = result.
- Saturate:
  - SIGNED=1: clamp r to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - SIGNED=0: clamp r to [0, 2^OUT_W-1].
  - out_sat=1 only when clamping occurred.
  - If OUT_W is at least the width of r, no clamping is possible and out_sat is always 0.
- When out_valid=0, out_p and out_sat hold their last values.
- Simultaneous events: back-to-back groups are supported; a new group's first sample may follow the in_last sample on the next edge, with no bubble required.
- An acc_mode=0 sample adjacent to group samples does not perturb group results.

Test Plan:
- Defaults. Accept a=-512, b=-512; then a=511, b=-512; then a=0, b=7 on consecutive edges. -> out_valid high 3 cycles later for 3 consecutive cycles with out_p=262144, -261632, 0; out_sat=0.
- Defaults. acc_mode=1, four samples a=100, b=100, in_last on the 4th, with a standalone a=2, b=3 inserted between samples 2 and 3. -> Outputs 6, then 40000 exactly 3 cycles after the 4th sample. Exactly two out_valid pulses.
- OUT_W=16, SIGNED=1. Input a=-512, b=-512. -> out_p=32767, out_sat=1. Input a=-512, b=511 -> out_p=-32768, out_sat=1.
- SHIFT=4. Inputs 3*3, then -3*3, then 1*8. -> out_p=1 ((9+8)>>4), -1 ((-9+8)>>4), 1 (tie rounds up); out_sat=0.
- SIGNED=0, OUT_W=16. Input a=1023, b=1023. -> out_p=65535, out_sat=1.
- Reset mid-operation:
  - Open a group with two samples (50*50) and assert rst for 1 cycle during the pipeline. -> out_valid stays 0 and no result emerges.
  - Then a group of one sample 3*4 with in_last. -> out_p=12.
